// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS sine/square/triangle/sawtooth source for an 8-bit parallel DAC.
// New settings arrive via a valid/ready handshake and are swapped in at the phase wrap.
module dds_wave_gen #(
  parameter int ACC_W = 32,
  parameter int PH_W = 10,
  parameter logic [7:0] IDLE_CODE = 8'h80
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic [PH_W-1:0]  cfg_phase,
  input  logic [7:0]       cfg_amp,
  input  logic [1:0]       cfg_wave,
  output logic             running,
  output logic             da_clk,
  output logic [7:0]       da_data
);
  localparam int QW = PH_W - 2;
  localparam int QD = 1 << QW;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  typedef struct packed {
    logic [ACC_W-1:0] ftw;
    logic [PH_W-1:0]  phase;
    logic [7:0]       amp;
    logic [1:0]       wave;
  } cfg_t;
  state_t state, state_nx;
  cfg_t act, shd, cfg_in;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  logic accept, go, wrap;
  logic [PH_W-1:0] ph1;
  logic [1:0] wave1;
  logic [7:0] amp1, amp2;
  logic v1, v2;
  logic signed [7:0] s, s2, s_sin, s_sq, s_tri, s_saw;
  logic signed [16:0] prod;
  logic [QW-1:0] idx;
  logic [PH_W-2:0] tx;
  logic [PH_W+6:0] tri_p;
  logic [7:0] t, raw;
  logic [6:0] lut [QD];
  function automatic logic [6:0] sin_q(input int i);
    return 7'($rtoi(127.0 * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(QD)) + 0.5));
  endfunction
  // quarter-wave table is fixed at elaboration
  for (genvar i = 0; i < QD; i++) begin : g_lut
    assign lut[i] = sin_q(i);
  end
  assign cfg_in = {cfg_ftw, cfg_phase, cfg_amp, cfg_wave};
  assign accept = cfg_valid & cfg_ready;
  assign go = running & enable;
  assign sum = {1'b0, acc} + {1'b0, act.ftw};
  assign wrap = sum[ACC_W];
  assign da_clk = ~clk;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = enable ? RUN : IDLE;
      RUN: state_nx = !enable ? IDLE : accept ? PEND : RUN;
      PEND: state_nx = !enable ? IDLE : wrap ? RUN : PEND;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cfg_ready = state != PEND;
    running = state != IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      act <= '0;
      shd <= '0;
    end else begin
      if (accept) shd <= cfg_in;
      if (state == IDLE && accept) act <= cfg_in;
      else if (state == PEND && enable && wrap) act <= shd;
    end
  always_comb begin
    idx = ph1[PH_W-2] ? ~ph1[QW-1:0] : ph1[QW-1:0];
    s_sin = ph1[PH_W-1] ? -$signed({1'b0, lut[idx]}) : $signed({1'b0, lut[idx]});
    s_sq = ph1[PH_W-1] ? 8'sh81 : 8'sh7f;
    tx = ph1[PH_W-2:0];
    tri_p = {tx, 8'd0} - {8'd0, tx};
    t = 8'(tri_p >> (PH_W - 1));
    s_tri = ph1[PH_W-1] ? 8'd127 - t : t - 8'd127;
    raw = {~ph1[PH_W-1], ph1[PH_W-2 -: 7]};
    s_saw = raw == 8'h80 ? 8'sh81 : raw;
    s = wave1 == 2'd0 ? s_sin : wave1 == 2'd1 ? s_sq : wave1 == 2'd2 ? s_tri : s_saw;
  end
  assign prod = s2 * $signed({1'b0, amp2});
  // a stop flushes every stage so the DAC returns to mid-scale on the next clock
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      acc <= '0;
      ph1 <= '0;
      wave1 <= '0;
      amp1 <= '0;
      v1 <= 1'b0;
      s2 <= '0;
      amp2 <= '0;
      v2 <= 1'b0;
      da_data <= IDLE_CODE;
    end else begin
      acc <= go ? sum[ACC_W-1:0] : '0;
      ph1 <= acc[ACC_W-1 -: PH_W] + act.phase;
      wave1 <= act.wave;
      amp1 <= act.amp;
      v1 <= go;
      s2 <= s;
      amp2 <= amp1;
      v2 <= v1 & go;
      da_data <= (v2 && go) ? 8'(prod >>> 8) + 8'd128 : IDLE_CODE;
    end
endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed vectors for static outputs plus streamed
// sequences for reconfiguration, stop, restart and async reset.
module tb_dds_wave_gen;
  localparam real PI = 3.141592653589793;
  localparam logic [31:0] F1 = 32'h051EB852;
  logic clk = 0, rstn = 1, enable = 0, cfg_valid = 0;
  logic [31:0] cfg_ftw = 0;
  logic [9:0] cfg_phase = 0;
  logic [7:0] cfg_amp = 0;
  logic [1:0] cfg_wave = 0;
  logic cfg_ready, running, da_clk;
  logic [7:0] da_data;
  logic [31:0] m_ftw;
  logic [9:0] m_ph;
  logic [7:0] m_amp;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {
    logic [9:0] ph;
    logic [7:0] amp;
    logic [1:0] wave;
    logic [7:0] want;
  } vec_t;
  vec_t vt[18];

  dds_wave_gen dut (
    .clk(clk), .rstn(rstn), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_wave(cfg_wave),
    .running(running), .da_clk(da_clk), .da_data(da_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  // sine written as signed magnitude of a full-period sine sampled mid-step
  function automatic logic [7:0] sine_da(input logic [9:0] ph, input logic [7:0] amp);
    real v;
    int q, sv;
    v = 127.0 * $sin(2.0 * PI * (real'(ph) + 0.5) / 1024.0);
    q = $rtoi((v < 0.0 ? -v : v) + 0.5);
    sv = ph[9] ? -q : q;
    return 8'(128 + ((sv * int'(amp)) >>> 8));
  endfunction

  task automatic load(input logic [31:0] f, input logic [9:0] p, input logic [7:0] a,
                      input logic [1:0] w);
    cfg_valid = 1; cfg_ftw = f; cfg_phase = p; cfg_amp = a; cfg_wave = w;
    m_ftw = f; m_ph = p; m_amp = a;
    @(negedge clk);
    cfg_valid = 0;
  endtask

  // enables the sine generator and checks every sample against an accumulator model
  task automatic stream(input int n, input int offer, input logic [31:0] nf);
    logic [31:0] ma, mf;
    logic [32:0] sm;
    logic pend;
    logic [7:0] hist[$];
    ma = 0; mf = m_ftw; pend = 0;
    enable = 1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("stream_run k=%0d", k), running, 1);
      chk($sformatf("stream_da k=%0d", k), da_data, k < 3 ? 8'h80 : hist[k-3]);
      chk($sformatf("stream_ready k=%0d", k), cfg_ready, !pend);
      hist.push_back(sine_da(10'(ma[31:22] + m_ph), m_amp));
      cfg_valid = (k == offer);
      cfg_ftw = nf;
      sm = {1'b0, ma} + {1'b0, mf};
      if (pend && sm[32]) begin
        mf = nf;
        pend = 0;
      end else if (k == offer) pend = 1;
      ma = sm[31:0];
      @(negedge clk);
    end
    cfg_valid = 0;
  endtask

  initial begin
    int last, per;
    logic [7:0] mx, mn, prev;
    vt[0]  = '{10'd256,  8'd255, 2'd0, 8'd254};
    vt[1]  = '{10'd768,  8'd255, 2'd0, 8'd1};
    vt[2]  = '{10'd0,    8'd255, 2'd0, 8'd128};
    vt[3]  = '{10'd128,  8'd255, 2'd0, 8'd217};
    vt[4]  = '{10'd640,  8'd255, 2'd0, 8'd38};
    vt[5]  = '{10'd256,  8'd128, 2'd0, 8'd191};
    vt[6]  = '{10'd0,    8'd128, 2'd1, 8'd191};
    vt[7]  = '{10'd512,  8'd128, 2'd1, 8'd64};
    vt[8]  = '{10'd100,  8'd0,   2'd1, 8'd128};
    vt[9]  = '{10'd0,    8'd255, 2'd2, 8'd1};
    vt[10] = '{10'd511,  8'd255, 2'd2, 8'd254};
    vt[11] = '{10'd512,  8'd255, 2'd2, 8'd254};
    vt[12] = '{10'd256,  8'd255, 2'd2, 8'd128};
    vt[13] = '{10'd1023, 8'd255, 2'd2, 8'd1};
    vt[14] = '{10'd0,    8'd255, 2'd3, 8'd1};
    vt[15] = '{10'd1023, 8'd255, 2'd3, 8'd254};
    vt[16] = '{10'd512,  8'd200, 2'd3, 8'd128};
    vt[17] = '{10'd768,  8'd128, 2'd3, 8'd160};

    #3 rstn = 0;
    @(negedge clk);
    chk("reset_da", da_data, 8'h80);
    chk("reset_ready", cfg_ready, 1);
    chk("reset_running", running, 0);
    chk("da_clk_inv", da_clk, 1);
    rstn = 1;
    repeat (4) @(negedge clk);
    chk("idle_da", da_data, 8'h80);
    chk("idle_running", running, 0);
    chk("idle_ready", cfg_ready, 1);

    foreach (vt[i]) begin
      load(32'd0, vt[i].ph, vt[i].amp, vt[i].wave);
      enable = 1;
      @(negedge clk);
      chk($sformatf("vec%0d_run", i), running, 1);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_latency", i), da_data, 8'h80);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), da_data, vt[i].want);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_hold", i), da_data, vt[i].want);
      enable = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_stop_da", i), da_data, 8'h80);
      chk($sformatf("vec%0d_stop_run", i), running, 0);
    end

    load(F1, 10'd0, 8'd255, 2'd0);
    enable = 1;
    @(negedge clk);
    last = -1; per = 0; mx = 0; mn = 255; prev = 128;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (da_data > mx) mx = da_data;
      if (da_data < mn) mn = da_data;
      if (prev < 128 && da_data >= 128) begin
        if (last >= 0) per = k - last;
        last = k;
      end
      prev = da_data;
    end
    chk("sine_max", mx, 254);
    chk("sine_min", mn, 1);
    chk("sine_period_49_51", per >= 49 && per <= 51, 1);
    enable = 0;
    @(negedge clk);

    load(F1, 10'd0, 8'd255, 2'd0);
    stream(160, 20, {F1[30:0], 1'b0});
    enable = 0;
    @(negedge clk);
    chk("reconf_stop_da", da_data, 8'h80);

    load(F1, 10'd0, 8'd255, 2'd0);
    stream(25, 10, {F1[30:0], 1'b0});
    enable = 0;
    @(negedge clk);
    chk("drop_da", da_data, 8'h80);
    chk("drop_running", running, 0);
    chk("drop_ready", cfg_ready, 1);
    stream(12, -1, 32'd0);

    #2 rstn = 0;
    #1;
    chk("async_rst_da", da_data, 8'h80);
    chk("async_rst_running", running, 0);
    chk("async_rst_ready", cfg_ready, 1);
    @(negedge clk);
    rstn = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_running", running, 1);
    chk("post_rst_cfg_cleared", da_data, 8'h80);
    enable = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
